key_tdr_lockout: RTL

- Key test-data register that sits directly upstream of a key-locked SIB (SMLSIB with on-chip key comparator).
- The key is scanned in over the IJTAG serial path and latched into a shadow register on update. The shadow register drives the KBits bus consumed by the comparator.
- Counts key update attempts and enters a permanent lockout after a configurable number of attempts; only reset clears the lockout.
- Capture never exposes key material.

---
 rtl/key_tdr_lockout.sv | 118 +++++++++++
 1 files changed

// File: rtl/key_tdr_lockout.sv
// Key test-data register feeding a key-locked SIB comparator, with attempt-count lockout.
// Optional build macro KEY_TDR_SO_MASK_EN forces SO low so key bits never leave the register.
module key_tdr_lockout #(
  parameter int Length      = 128,
  parameter int MaxAttempts = 8
) (
  input  logic              Clock,
  input  logic              RstBar,
  input  logic              SI,
  input  logic              ShiftEN,
  input  logic              CaptureEN,
  input  logic              UpdateEn,
  input  logic              Select,
  output logic              SO,
  output logic [Length-1:0] KBits,
  output logic              Locked
);

  localparam logic [7:0] MAX_CNT = MaxAttempts[7:0];

  typedef enum logic [0:0] {
    ARMED  = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [Length-1:0] sr_r;
  logic [Length-1:0] shadow_r;
  logic [7:0]        cnt_r;
  logic              locked_r;
  logic              cap_s;
  logic              shf_s;
  logic              upd_s;
  logic              limit_s;

  // Enable decode: only the highest-priority asserted enable acts, and only when selected.
  always_comb begin
    cap_s = 1'b0;
    shf_s = 1'b0;
    upd_s = 1'b0;
    if (Select) begin
      cap_s = CaptureEN;
      shf_s = ShiftEN & ~CaptureEN;
      upd_s = UpdateEn & ~ShiftEN & ~CaptureEN;
    end else begin
      cap_s = 1'b0;
      shf_s = 1'b0;
      upd_s = 1'b0;
    end
  end

  assign limit_s = ((cnt_r + 8'd1) == MAX_CNT);

  // Next-state logic: LOCKED is absorbing; only the asynchronous reset leaves it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARMED: begin
        if (upd_s && limit_s) state_nxt_s = LOCKED;
        else                  state_nxt_s = ARMED;
      end
      LOCKED:  state_nxt_s = LOCKED;
      default: state_nxt_s = LOCKED;
    endcase
  end

  // State register and registered lockout flag.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      state_r  <= ARMED;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      locked_r <= (state_nxt_s == LOCKED);
    end
  end

  // Scan shift register: capture loads zeros so the key can never be read back.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      sr_r <= '0;
    end else if (cap_s) begin
      sr_r <= '0;
    end else if (shf_s) begin
      sr_r <= {SI, sr_r[Length-1:1]};
    end else begin
      sr_r <= sr_r;
    end
  end

  // Shadow key and saturating attempt counter; the limit-hitting update still lands.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      shadow_r <= '0;
      cnt_r    <= 8'd0;
    end else if (state_r == LOCKED) begin
      shadow_r <= '0;
      cnt_r    <= cnt_r;
    end else if (upd_s) begin
      shadow_r <= sr_r;
      cnt_r    <= (cnt_r == MAX_CNT) ? cnt_r : (cnt_r + 8'd1);
    end else begin
      shadow_r <= shadow_r;
      cnt_r    <= cnt_r;
    end
  end

`ifdef KEY_TDR_SO_MASK_EN
  assign SO = 1'b0;
`else
  assign SO = sr_r[0];
`endif

  assign KBits  = shadow_r;
  assign Locked = locked_r;

endmodule
